regfile_2r1w_sync: RTL and testbench

Parametrised next-generation register file: two registered read ports, one write port, same-cycle write-to-read bypass, optional hardwired-zero register 0. After reset, a clear sequencer zeroes every entry one per cycle, so power-up contents are deterministic. Sits between decode (read addresses) and writeback (write port) of the datapath; `busy` stalls the pipeline during the clear.

---
 rtl/regfile_2r1w_sync.sv | 169 ++++++++++++++++
 tb/tb_regfile_2r1w_sync.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sync.sv
// rtl/regfile_2r1w_sync.sv - two-read one-write register file with post-reset clear sequencer
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     synchronous active-high reset; restarts the clear sequence
//   we        write enable
//   waddr     write address
//   wdata     write data
//   rd_en_a   read request, port A
//   raddr_a   read address, port A
//   rdata_a   registered read data, port A (holds when rd_en_a is low)
//   rvalid_a  rdata_a valid this cycle
//   rd_en_b   read request, port B
//   raddr_b   read address, port B
//   rdata_b   registered read data, port B (holds when rd_en_b is low)
//   rvalid_b  rdata_b valid this cycle
//   busy      clear sequence in progress; reads and writes not serviced
//   wr_drop   one-cycle pulse: the previous cycle's write was discarded

module regfile_2r1w_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;
  logic                  busy_q, busy_d;
  logic                  wr_drop_q, wr_drop_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  eff_we;
  logic [DATA_WIDTH-1:0] rd_val_a, rd_val_b;

  // Writes to entry 0 are discarded when it is hardwired to zero.
  assign eff_we = we && !(HAS_ZERO && (waddr == '0));

  // Read value priority: hardwired zero, then same-edge write bypass, then storage.
  always_comb begin
    if (HAS_ZERO && (raddr_a == '0)) begin
      rd_val_a = '0;
    end else if (eff_we && (waddr == raddr_a)) begin
      rd_val_a = wdata;
    end else begin
      rd_val_a = mem_q[raddr_a];
    end
  end

  always_comb begin
    if (HAS_ZERO && (raddr_b == '0)) begin
      rd_val_b = '0;
    end else if (eff_we && (waddr == raddr_b)) begin
      rd_val_b = wdata;
    end else begin
      rd_val_b = mem_q[raddr_b];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    busy_d     = busy_q;
    wr_drop_d  = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wdata  = wdata;

    case (state_q)
      ST_CLEAR: begin
        // One entry per cycle; any external write attempt is reported as dropped.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        wr_drop_d = we;
        if (clr_ptr_q == '1) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        mem_we     = eff_we;
        wr_drop_d  = we && !eff_we;
        rvalid_a_d = rd_en_a;
        rvalid_b_d = rd_en_b;
        if (rd_en_a) begin
          rdata_a_d = rd_val_a;
        end
        if (rd_en_b) begin
          rdata_b_d = rd_val_b;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      busy_q     <= 1'b1;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      busy_q     <= busy_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Storage has no reset; it is left untouched while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = busy_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_2r1w_sync.sv
// tb/tb_regfile_2r1w_sync.sv - self-checking bench for regfile_2r1w_sync (ZERO_REG=1 and ZERO_REG=0)

module tb_regfile_2r1w_sync;

  localparam int DEPTH = 32;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rd_en_a, rd_en_b;
  logic [4:0]  raddr_a, raddr_b;

  logic [31:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;
  logic        rvalid_a1, rvalid_b1, rvalid_a0, rvalid_b0;
  logic        busy1, busy0, wr_drop1, wr_drop0;

  regfile_2r1w_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) u_dut_z1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en_a(rd_en_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .rd_en_b(rd_en_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .busy(busy1), .wr_drop(wr_drop1)
  );

  regfile_2r1w_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en_a(rd_en_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .rd_en_b(rd_en_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .busy(busy0), .wr_drop(wr_drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model; index 1 = hardwired zero register, index 0 = ordinary entry 0.
  logic [31:0] m_mem [2][DEPTH];
  logic [31:0] m_rdata_a [2];
  logic [31:0] m_rdata_b [2];
  logic        m_wr_drop [2];
  logic        m_rvalid_a, m_rvalid_b, m_busy;
  bit          m_clearing;
  int          m_clear_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_clearing   = 1'b1;
      m_clear_done = 0;
      m_rvalid_a   = 1'b0;
      m_rvalid_b   = 1'b0;
      m_busy       = 1'b1;
      for (int z = 0; z < 2; z++) begin
        m_rdata_a[z] = '0;
        m_rdata_b[z] = '0;
        m_wr_drop[z] = 1'b0;
      end
    end else if (m_clearing) begin
      for (int z = 0; z < 2; z++) begin
        m_mem[z][m_clear_done] = '0;
        m_wr_drop[z] = we;
      end
      m_clear_done++;
      m_rvalid_a = 1'b0;
      m_rvalid_b = 1'b0;
      if (m_clear_done == DEPTH) begin
        m_clearing = 1'b0;
        m_busy     = 1'b0;
      end
    end else begin
      for (int z = 0; z < 2; z++) begin
        bit eff;
        eff = we && !(z == 1 && waddr == 0);
        if (rd_en_a)
          m_rdata_a[z] = (z == 1 && raddr_a == 0) ? 32'h0 :
                         (eff && waddr == raddr_a) ? wdata : m_mem[z][raddr_a];
        if (rd_en_b)
          m_rdata_b[z] = (z == 1 && raddr_b == 0) ? 32'h0 :
                         (eff && waddr == raddr_b) ? wdata : m_mem[z][raddr_b];
        if (eff) m_mem[z][waddr] = wdata;
        m_wr_drop[z] = we && !eff;
      end
      m_rvalid_a = rd_en_a;
      m_rvalid_b = rd_en_b;
    end
  endtask

  task automatic check_model();
    chk("m_rdata_a_z1", rdata_a1, m_rdata_a[1]);
    chk("m_rdata_b_z1", rdata_b1, m_rdata_b[1]);
    chk("m_rdata_a_z0", rdata_a0, m_rdata_a[0]);
    chk("m_rdata_b_z0", rdata_b0, m_rdata_b[0]);
    chk("m_rvalid_a_z1", rvalid_a1, m_rvalid_a);
    chk("m_rvalid_b_z1", rvalid_b1, m_rvalid_b);
    chk("m_rvalid_a_z0", rvalid_a0, m_rvalid_a);
    chk("m_rvalid_b_z0", rvalid_b0, m_rvalid_b);
    chk("m_busy_z1", busy1, m_busy);
    chk("m_busy_z0", busy0, m_busy);
    chk("m_wr_drop_z1", wr_drop1, m_wr_drop[1]);
    chk("m_wr_drop_z0", wr_drop0, m_wr_drop[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ra_en, input logic [4:0] ra,
                       input logic rb_en, input logic [4:0] rb);
    we = w; waddr = wa; wdata = wd;
    rd_en_a = ra_en; raddr_a = ra;
    rd_en_b = rb_en; raddr_b = rb;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rd_en_a;
    logic [4:0]  raddr_a;
    logic        rd_en_b;
    logic [4:0]  raddr_b;
    logic [31:0] exp_a1;
    logic [31:0] exp_a0;
    logic [31:0] exp_b1;
    logic [31:0] exp_b0;
    logic        exp_drop1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n;

    vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd4, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 5'd3, 32'h12345678, 1'b1, 5'd3, 1'b1, 5'd4,
                32'h12345678, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd3,
                32'h0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0};
    vecs[6] = '{1'b1, 5'd5, 32'h55AA55AA, 1'b1, 5'd5, 1'b1, 5'd5,
                32'h55AA55AA, 32'h55AA55AA, 32'h55AA55AA, 32'h55AA55AA, 1'b0};
    vecs[7] = '{1'b1, 5'd0, 32'h11111111, 1'b1, 5'd0, 1'b1, 5'd0,
                32'h0, 32'h11111111, 32'h0, 32'h11111111, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Power-up reset and full clear.
    step();
    step();
    chk("rst_busy", busy1, 1'b1);
    chk("rst_rvalid_a", rvalid_a1, 1'b0);
    chk("rst_rdata_a", rdata_a1, 32'h0);
    chk("rst_wr_drop", wr_drop1, 1'b0);
    reset = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (busy1 && n < 40);
    chk("clear_len", 32'(n), 32'd32);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(DEPTH - 1 - i));
      step();
      chk("clr_rvalid_a", rvalid_a1, 1'b1);
      chk("clr_rvalid_b", rvalid_b0, 1'b1);
      chk("clr_rdata_a_z0", rdata_a0, 32'h0);
      chk("clr_rdata_b_z0", rdata_b0, 32'h0);
    end

    // Write/read, bypass and hardwired-zero vectors.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].rd_en_a, vecs[i].raddr_a, vecs[i].rd_en_b, vecs[i].raddr_b);
      step();
      chk("vec_rvalid_a", rvalid_a1, vecs[i].rd_en_a);
      chk("vec_rvalid_b", rvalid_b0, vecs[i].rd_en_b);
      if (vecs[i].rd_en_a) begin
        chk("vec_rdata_a_z1", rdata_a1, vecs[i].exp_a1);
        chk("vec_rdata_a_z0", rdata_a0, vecs[i].exp_a0);
      end
      if (vecs[i].rd_en_b) begin
        chk("vec_rdata_b_z1", rdata_b1, vecs[i].exp_b1);
        chk("vec_rdata_b_z0", rdata_b0, vecs[i].exp_b0);
      end
      chk("vec_wr_drop_z1", wr_drop1, vecs[i].exp_drop1);
      chk("vec_wr_drop_z0", wr_drop0, 1'b0);
    end

    // Reset mid-operation with writes attempted during the clear.
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    step();
    chk("pre_rst_rd9", rdata_a1, 32'hA5A5A5A5);
    reset = 1'b1;
    drive(1'b1, 5'd9, 32'h5A5A5A5A, 1'b1, 5'd9, 1'b1, 5'd9);
    step();
    chk("rst_mid_rvalid", rvalid_a1, 1'b0);
    chk("rst_mid_rdata", rdata_a1, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t5_wr_drop", wr_drop1, 1'b1);
      chk("t5_rvalid", rvalid_b1, 1'b0);
      chk("t5_busy", busy1, (i < DEPTH - 1) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    step();
    chk("t5_rd9_a", rdata_a1, 32'h0);
    chk("t5_rd9_b", rdata_b0, 32'h0);
    chk("t5_drop_clr", wr_drop1, 1'b0);

    // Reset at clear cycle 10 restarts the whole clear.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      chk("t6_rvalid", rvalid_a1, 1'b0);
    end while (busy1 && n < 40);
    chk("t6_clear_len", 32'(n), 32'd32);
    chk("t6_rdata_hold", rdata_b1, 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 119) == 0);
      we      = 1'($urandom);
      waddr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wdata   = $urandom;
      rd_en_a = 1'($urandom);
      rd_en_b = 1'($urandom);
      raddr_a = $urandom_range(0, 1) ? waddr : 5'($urandom);
      raddr_b = $urandom_range(0, 1) ? waddr : 5'($urandom);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
